// File: rtl/skid_buffer.sv
// Two-entry registered valid/ready stage: main register drives the output,
// skid register absorbs the one extra beat accepted when the consumer stalls.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [1:0]       occ_q, occ_d;
  logic             push_c, pop_c;

  assign push_c = s_valid & s_ready_q;
  assign pop_c  = m_valid_q & m_ready;

  // Next-state, storage and registered-flag computation
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push_c) begin
          main_d  = s_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (push_c && !pop_c) begin
          skid_d  = s_data;
          state_d = ST_FULL;
        end else if (push_c && pop_c) begin
          main_d  = s_data;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flags are derived from the next state so they leave the block as flops
    s_ready_d = (state_d != ST_FULL);
    m_valid_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_BUSY: occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      occ_q     <= occ_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign occupancy = occ_q;

endmodule
